// File: rtl/minilab_0_if.sv
// Board I/O bundle for Minilab 0: slide switches in, seven-segment
// displays and LED bar out. Clocks and KEY (which carries reset) stay
// as plain ports on the top module.
interface minilab_0_if;
    logic [9:0] SW;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;
    logic [9:0] LEDR;

    // Board / testbench side: drives switches, watches displays
    modport master (
        output SW,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR
    );

    // Design side: reads switches, drives displays
    modport slave (
        input  SW,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR
    );
endinterface

// File: rtl/minilab_0.sv
// Minilab 0 board top: fills two FIFOs with fixed operand sequences,
// drains them in lockstep through a multiply-accumulate, then shows the
// 24-bit dot product on HEX5..HEX0 and the controller state on LEDR.

// First-word-fall-through FIFO: dout is the head entry combinationally.
// Writes when full and reads when empty are dropped.
module minilab_0_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  do_wr;
    logic                  do_rd;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Next pointer/count; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module minilab_0 #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic        CLOCK_50,
    input  logic        CLOCK2_50,
    input  logic        CLOCK3_50,
    input  logic        CLOCK4_50,
    input  logic [3:0]  KEY,
    minilab_0_if.slave  brd
);
    localparam int CNT_W  = $clog2(DEPTH);
    localparam int PROD_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    logic                  clk;
    logic                  rst_n;
    state_t                state_q;
    logic [CNT_W-1:0]      fill_cnt_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]  acc_d;

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din_a, din_b;
    logic [DATA_WIDTH-1:0] dout_a, dout_b;
    logic                  full_a, full_b;
    logic                  empty_a, empty_b;
    logic [PROD_W-1:0]     prod;
    logic [6:0]            hex_d [6];
    logic                  unused_pins;

    assign clk   = CLOCK_50;
    assign rst_n = KEY[0];

    // Spare board inputs are deliberately ignored
    assign unused_pins = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY[3:1], brd.SW};

    // Seven-segment encoder, active-low, bit0=a .. bit6=g
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // FIFO A gets 1..DEPTH, FIFO B gets 11..DEPTH+10, one pair per FILL cycle
    assign wr_en = (state_q == FILL);
    assign din_a = DATA_WIDTH'(fill_cnt_q) + DATA_WIDTH'(1);
    assign din_b = DATA_WIDTH'(fill_cnt_q) + DATA_WIDTH'(11);

    // Pop both heads together only when both hold data
    assign rd_en = (state_q == EXEC) && !empty_a && !empty_b;

    // Unsigned product, zero-extended into the wrapping accumulator
    assign prod  = dout_a * dout_b;
    assign acc_d = acc_q + ACC_WIDTH'(prod);

    minilab_0_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (wr_en),
        .din_i   (din_a),
        .rd_en_i (rd_en),
        .dout_o  (dout_a),
        .full_o  (full_a),
        .empty_o (empty_a)
    );

    minilab_0_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (wr_en),
        .din_i   (din_b),
        .rd_en_i (rd_en),
        .dout_o  (dout_b),
        .full_o  (full_b),
        .empty_o (empty_b)
    );

    // Controller: fill, multiply-accumulate until drained, then hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    fill_cnt_q <= fill_cnt_q + CNT_W'(1);
                    if (fill_cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (rd_en) begin
                        acc_q <= acc_d;
                    end else if (empty_a && empty_b) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q    <= FILL;
                    fill_cnt_q <= '0;
                    acc_q      <= '0;
                end
            endcase
        end
    end

    // Displays blank except in DONE, where HEXn shows nibble n of acc
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            hex_d[k] = 7'h7F;
        end
        if (state_q == DONE) begin
            for (int k = 0; k < 6; k++) begin
                hex_d[k] = seg7(acc_q[4*k +: 4]);
            end
        end
    end

    assign brd.HEX0 = hex_d[0];
    assign brd.HEX1 = hex_d[1];
    assign brd.HEX2 = hex_d[2];
    assign brd.HEX3 = hex_d[3];
    assign brd.HEX4 = hex_d[4];
    assign brd.HEX5 = hex_d[5];
    assign brd.LEDR = {8'd0, state_q};
endmodule

// File: tb/tb_minilab_0.sv
// Testbench for minilab_0: reset behaviour, fill/exec/done sequencing,
// display encoding and mid-run aborts, with random switch/key noise.
module tb_minilab_0;
    logic       CLOCK_50;
    logic       CLOCK2_50, CLOCK3_50, CLOCK4_50;
    logic [3:0] KEY;

    int n_vec;
    int n_err;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    minilab_0_if brd ();

    minilab_0 dut (
        .CLOCK_50  (CLOCK_50),
        .CLOCK2_50 (CLOCK2_50),
        .CLOCK3_50 (CLOCK3_50),
        .CLOCK4_50 (CLOCK4_50),
        .KEY       (KEY),
        .brd       (brd)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: state as a function of edges since reset release
    function automatic logic [1:0] ref_state(input int e);
        if (e < 8)  return 2'd0;
        if (e < 17) return 2'd1;
        return 2'd2;
    endfunction

    // Reference: dot product of the operands consumed so far
    function automatic logic [23:0] ref_acc(input int e);
        int qa[$];
        int qb[$];
        int n;
        logic [23:0] a;
        for (int i = 1; i <= 8; i++) begin
            qa.push_back(i);
            qb.push_back(i + 10);
        end
        n = (e <= 8) ? 0 : ((e - 8 > 8) ? 8 : e - 8);
        a = '0;
        repeat (n) a = a + 24'(qa.pop_front() * qb.pop_front());
        return a;
    endfunction

    function automatic logic [41:0] ref_hex(input logic [1:0] st, input logic [23:0] a);
        logic [41:0] h;
        h = {6{7'h7F}};
        if (st == 2'd2) begin
            for (int k = 0; k < 6; k++) h[7*k +: 7] = SEG[a[4*k +: 4]];
        end
        return h;
    endfunction

    function automatic logic [41:0] hex_bus();
        return {brd.HEX5, brd.HEX4, brd.HEX3, brd.HEX2, brd.HEX1, brd.HEX0};
    endfunction

    task automatic noise();
        brd.SW = 10'($urandom);
        KEY    = {3'($urandom), KEY[0]};
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ledr"}, 64'(brd.LEDR), 64'h0);
        check_val({tag, "_hex"},  64'(hex_bus()), 64'({6{7'h7F}}));
    endtask

    // Release reset and step n_edges, checking after each; optionally
    // pull reset low right after edge abort_at and hold it one cycle.
    task automatic run_seq(input int n_edges, input int abort_at);
        logic [1:0]  st;
        logic [23:0] a;
        KEY[0] = 1'b1;
        for (int e = 1; e <= n_edges; e++) begin
            @(posedge CLOCK_50);
            #1;
            st = ref_state(e);
            a  = ref_acc(e);
            check_val($sformatf("ledr_e%0d", e), 64'(brd.LEDR), 64'({8'd0, st}));
            check_val($sformatf("hex_e%0d", e),  64'(hex_bus()), 64'(ref_hex(st, a)));
            check_val($sformatf("acc_e%0d", e),  64'(dut.acc_q), 64'(a));
            if (e == 8) begin
                check_val("full_a_e8", 64'(dut.u_fifo_a.full_o), 64'd1);
                check_val("full_b_e8", 64'(dut.u_fifo_b.full_o), 64'd1);
                check_val("head_a_e8", 64'(dut.u_fifo_a.dout_o), 64'd1);
                check_val("head_b_e8", 64'(dut.u_fifo_b.dout_o), 64'd11);
            end
            noise();
            if (e == abort_at) begin
                KEY[0] = 1'b0;
                #1;
                check_reset_outputs("abort_now");
                check_val("abort_acc", 64'(dut.acc_q), 64'h0);
                @(posedge CLOCK_50);
                #1;
                check_reset_outputs("abort_hold");
                return;
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        CLOCK_50  = 1'b0;
        CLOCK2_50 = 1'b0;
        CLOCK3_50 = 1'b0;
        CLOCK4_50 = 1'b0;
        brd.SW    = '0;
        KEY       = 4'b1111;
        #1;
        KEY       = 4'b1110;
        #1;
        check_reset_outputs("rst_async");
        for (int c = 0; c < 4; c++) begin
            @(posedge CLOCK_50);
            #1;
            check_reset_outputs($sformatf("rst_c%0d", c));
        end

        run_seq(22, 0);
        check_val("done_hex0", 64'(brd.HEX0), 64'h19);
        check_val("done_hex1", 64'(brd.HEX1), 64'h30);
        check_val("done_hex2", 64'(brd.HEX2), 64'h24);
        check_val("done_hex5", 64'(brd.HEX5), 64'h40);

        KEY[0] = 1'b0;
        #1;
        check_reset_outputs("rerun_rst");
        @(posedge CLOCK_50);
        #1;
        run_seq(22, 12);
        run_seq(22, 0);

        KEY[0] = 1'b0;
        @(posedge CLOCK_50);
        #1;
        run_seq(22, int'($urandom_range(1, 16)));
        run_seq(22, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
